dm_lsu: RTL and testbench
=========================

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 Parameter ADDR_W, default 14, DM word-address width (16384 words, 64 KiB byte space).
REQ-002 Parameter SIM_END_WORD, default 14'h3fff, word address of the simulation-end mailbox.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  CPU memory request present.
REQ-006 req_ready  output  1  LSU able to accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load-only).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected (misaligned, out of range, illegal funct3), qualified by resp_valid.
REQ-014 dm_cs  output  1  DM chip select.
REQ-015 dm_oe  output  1  DM read enable.
REQ-016 dm_web  output  4  DM per-byte write enables, active-low, bit i = byte lane i.
REQ-017 dm_a  output  ADDR_W  DM word address.
REQ-018 dm_di  output  32  DM write data.
REQ-019 dm_do  input  32  DM read data, valid one cycle after dm_cs&dm_oe.
REQ-020 sim_done  output  1  sticky simulation-end flag.

Function
REQ-021 FSM states IDLE, ACCESS, LOAD_RESP, ERR_RESP; req_ready = 1 only in IDLE.
REQ-022 Handshake: request accepted on the edge where req_valid & req_ready; inputs registered at acceptance, ignored otherwise.
REQ-023 Legality check at acceptance: H/HU/SH need addr[0]=0; W needs addr[1:0]=0; addr[31:ADDR_W+2] must be 0; store with funct3 100/101 or any funct3 011/11x is illegal.
REQ-024 Illegal request: IDLE -> ERR_RESP; ERR_RESP: resp_valid=1, resp_err=1, resp_rdata=0, no DM access; -> IDLE.
REQ-025 Legal request: IDLE -> ACCESS; ACCESS drives dm_cs=1, dm_a=addr[ADDR_W+1:2].
REQ-026 Store in ACCESS: dm_oe=0, dm_web lanes cleared per size/offset (SB: one lane addr[1:0]; SH: lanes {addr[1]*2, +1}; SW: 4'b0000), dm_di = byte replicated x4 (SB), halfword x2 (SH), word (SW); resp_valid=1 same cycle; -> IDLE. Store latency 1 cycle after acceptance.
REQ-027 Load in ACCESS: dm_oe=1, dm_web=4'b1111; -> LOAD_RESP.
REQ-028 LOAD_RESP: select lane(s) of dm_do by registered addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), W pass-through; resp_valid=1, resp_err=0; -> IDLE. Load latency 2 cycles after acceptance.
REQ-029 Outside ACCESS: dm_cs=0, dm_oe=0, dm_web=4'b1111, dm_a and dm_di hold last value.
REQ-030 Back-to-back: next request acceptable in the cycle after resp_valid (IDLE re-entered); throughput 1 request / 2 cycles (store), / 3 cycles (load).
REQ-031 sim_done set on the ACCESS cycle of a SW to word SIM_END_WORD with data 32'hffffffff; never cleared except by reset; other sizes or data to that word do not set it.
REQ-032 Highest legal address: byte 0xFFFC SW writes word 0x3fff; byte 0x10000 is out of range -> error.

Reset
REQ-033 On rising clk with rst=0: state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, dm_cs=0, dm_oe=0, dm_web=4'b1111, dm_a=0, dm_di=0, sim_done=0, req_ready=0 during reset.
REQ-034 Reset asserted in ACCESS or LOAD_RESP aborts the operation: no DM write in the reset cycle, no resp_valid afterwards.

Structure
REQ-035 Package dm_lsu_pkg holds funct3 constants, FSM state enum, SIM_END_CODE (32'hffffffff).
REQ-036 One combinational sub-module dm_lsu_load_align (dm_do, offset, funct3 -> resp_rdata); store lane/replication logic stays in dm_lsu.

Verification
REQ-037 SW addr 0x8000 data 0x12345678 -> ACCESS: dm_a=0x2000, dm_web=0000, dm_di=0x12345678, resp_valid 1 cycle after acceptance.
REQ-038 DM word 0x2000 = 0x8899AABB; LB 0x8001 -> resp_rdata 0xFFFFFFAA; LBU 0x8001 -> 0x000000AA; LH 0x8002 -> 0xFFFF8899; each resp 2 cycles after acceptance.
REQ-039 SB addr 0x8003 data 0x000000C5 -> dm_web=0111, dm_di=0xC5C5C5C5; SH 0x8002 data 0x1234 -> dm_web=0011, dm_di=0x12341234.
REQ-040 LW 0x8002, SH 0x8001, LW 0x10000, SBU-style store funct3 100 -> each resp_err=1, resp_rdata=0, dm_cs never asserted.
REQ-041 SW 0xFFFC data 0xffffffff -> sim_done=1 and stays 1 through later traffic; SW 0xFFFC data 0xfffffffe from reset -> sim_done stays 0.
REQ-042 Load accepted, rst=0 asserted in LOAD_RESP-entry cycle -> no resp_valid, all outputs at REQ-033 values, next request after release completes normally.

Source files
------------

// File: rtl/dm_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Holds funct3 size codes, the LSU FSM state enum and the sim-end code.
package dm_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] SIM_END_CODE = 32'hffffffff;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LOAD_RESP,
        ERR_RESP
    } state_t;

endpackage

// File: rtl/dm_lsu_load_align.sv
// Load-data lane select and sign/zero extension.
// Ports: dm_do (raw DM word), offset (byte offset), funct3 (size/sign) -> rdata.
module dm_lsu_load_align
    import dm_lsu_pkg::*;
(
    input  logic [31:0] dm_do,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (offset)
            2'd0:    b = dm_do[7:0];
            2'd1:    b = dm_do[15:8];
            2'd2:    b = dm_do[23:16];
            default: b = dm_do[31:24];
        endcase
        h = offset[1] ? dm_do[31:16] : dm_do[15:0];
        case (funct3)
            F3_B:    rdata = {{24{b[7]}}, b};
            F3_H:    rdata = {{16{h[15]}}, h};
            F3_BU:   rdata = {24'd0, b};
            F3_HU:   rdata = {16'd0, h};
            default: rdata = dm_do;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit between the CPU request port and a single-port data memory.
// Ports: clk/rst (sync, active-low), req_* CPU request, resp_* completion,
// dm_* memory interface, sim_done sticky simulation-end flag.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int                ADDR_W       = 14,
    parameter logic [ADDR_W-1:0] SIM_END_WORD = 14'h3fff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              dm_cs,
    output logic              dm_oe,
    output logic [3:0]        dm_web,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_di,
    input  logic [31:0]       dm_do,
    output logic              sim_done
);

    state_t      state, state_n;
    logic        q_we;
    logic [2:0]  q_f3;
    logic [1:0]  q_off;
    logic        f3_ok, align_ok, range_ok, legal, accept;
    logic [31:0] st_data;
    logic [3:0]  st_web;
    logic [31:0] ld_data;

    always_comb begin
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = ~req_we;
            default:          f3_ok = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        range_ok = ((req_addr >> (ADDR_W + 2)) == 32'd0);
        legal    = f3_ok & align_ok & range_ok;
        case (req_funct3[1:0])
            2'b00:   st_data = {4{req_wdata[7:0]}};
            2'b01:   st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
        case (q_f3[1:0])
            2'b00:   st_web = ~(4'b0001 << q_off);
            2'b01:   st_web = q_off[1] ? 4'b0011 : 4'b1100;
            default: st_web = 4'b0000;
        endcase
    end

    dm_lsu_load_align u_align (
        .dm_do  (dm_do),
        .offset (q_off),
        .funct3 (q_f3),
        .rdata  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        dm_cs      = 1'b0;
        dm_oe      = 1'b0;
        dm_web     = 4'b1111;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = legal ? ACCESS : ERR_RESP;
            end
            ACCESS: begin
                dm_cs = 1'b1;
                if (q_we) begin
                    dm_web     = st_web;
                    resp_valid = 1'b1;
                    state_n    = IDLE;
                end else begin
                    dm_oe   = 1'b1;
                    state_n = LOAD_RESP;
                end
            end
            LOAD_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = ld_data;
                state_n    = IDLE;
            end
            ERR_RESP: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_n    = IDLE;
            end
        endcase
        // Reset is synchronous, so gate outputs in the reset cycle itself
        // to keep an in-flight access from touching DM.
        if (!rst) begin
            state_n    = IDLE;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = 32'd0;
            dm_cs      = 1'b0;
            dm_oe      = 1'b0;
            dm_web     = 4'b1111;
        end
    end

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_we  <= 1'b0;
            q_f3  <= 3'd0;
            q_off <= 2'd0;
            dm_a  <= '0;
            dm_di <= 32'd0;
        end else if (accept && legal) begin
            q_we  <= req_we;
            q_f3  <= req_funct3;
            q_off <= req_addr[1:0];
            dm_a  <= req_addr[ADDR_W+1:2];
            if (req_we) dm_di <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sim_done <= 1'b0;
        end else if (dm_cs && q_we && q_f3 == F3_W &&
                     dm_a == SIM_END_WORD && dm_di == SIM_END_CODE) begin
            sim_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed scoreboard bench for dm_lsu with a behavioural DM model.
// Drives requests, queues expected responses, checks them on resp_valid.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_cs;
    logic        dm_oe;
    logic [3:0]  dm_web;
    logic [13:0] dm_a;
    logic [31:0] dm_di;
    logic [31:0] dm_do = 32'd0;
    logic        sim_done;

    dm_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_cs      (dm_cs),
        .dm_oe      (dm_oe),
        .dm_web     (dm_web),
        .dm_a       (dm_a),
        .dm_di      (dm_di),
        .dm_do      (dm_do),
        .sim_done   (sim_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    int          cs_cnt = 0;

    always @(posedge clk) begin
        if (dm_cs) begin
            cs_cnt++;
            for (int i = 0; i < 4; i++)
                if (!dm_web[i]) mem[dm_a][i*8 +: 8] <= dm_di[i*8 +: 8];
            if (dm_oe) dm_do <= mem[dm_a];
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [13:0] acc_a;
    logic [3:0]  acc_web;
    logic [31:0] acc_di;
    logic        acc_cs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            exp_t e;
            n_tests++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_resp: got rdata %h err %b expected none",
                       resp_rdata, resp_err);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, resp_rdata, e.rd);
                check({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        int lat;
        int cs0;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        sb_q.push_back('{tag, exp_rd, exp_err});
        cs0 = cs_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = 32'hdeadbeef;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                acc_a   = dm_a;
                acc_web = dm_web;
                acc_di  = dm_di;
                acc_cs  = dm_cs;
            end
        end while (resp_valid !== 1'b1 && lat < 6);
        check({tag, "_lat"}, lat, exp_lat);
        if (exp_err) check({tag, "_nocs"}, cs_cnt, cs0);
    endtask

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010;
    localparam logic [2:0] BU = 3'b100, HU = 3'b101;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_cs", {31'd0, dm_cs}, 32'd0);
        check("rst_oe", {31'd0, dm_oe}, 32'd0);
        check("rst_web", {28'd0, dm_web}, 32'hf);
        check("rst_a", {18'd0, dm_a}, 32'd0);
        check("rst_di", dm_di, 32'd0);
        check("rst_simdone", {31'd0, sim_done}, 32'd0);
        rst = 1'b1;

        do_req("sw_end_nearly", 1, W, 32'hfffc, 32'hfffffffe, 0, 0, 1);
        @(negedge clk);
        check("simdone_not_set", {31'd0, sim_done}, 32'd0);

        do_req("sw_8000", 1, W, 32'h8000, 32'h12345678, 0, 0, 1);
        check("sw_a", {18'd0, acc_a}, 32'h2000);
        check("sw_web", {28'd0, acc_web}, 32'h0);
        check("sw_di", acc_di, 32'h12345678);
        check("sw_cs", {31'd0, acc_cs}, 32'd1);
        @(negedge clk);
        check("idle_hold_a", {18'd0, dm_a}, 32'h2000);
        check("idle_cs", {31'd0, dm_cs}, 32'd0);
        do_req("lw_8000a", 0, W, 32'h8000, 0, 32'h12345678, 0, 2);

        do_req("sw_word", 1, W, 32'h8000, 32'h8899aabb, 0, 0, 1);
        do_req("lb_8001", 0, B, 32'h8001, 0, 32'hffffffaa, 0, 2);
        do_req("lbu_8001", 0, BU, 32'h8001, 0, 32'h000000aa, 0, 2);
        do_req("lh_8002", 0, H, 32'h8002, 0, 32'hffff8899, 0, 2);
        do_req("lhu_8002", 0, HU, 32'h8002, 0, 32'h00008899, 0, 2);
        do_req("lb_8000", 0, B, 32'h8000, 0, 32'hffffffbb, 0, 2);

        do_req("sb_8003", 1, B, 32'h8003, 32'h000000c5, 0, 0, 1);
        check("sb_web", {28'd0, acc_web}, 32'h7);
        check("sb_di", acc_di, 32'hc5c5c5c5);
        do_req("lw_after_sb", 0, W, 32'h8000, 0, 32'hc599aabb, 0, 2);
        do_req("sh_8002", 1, H, 32'h8002, 32'h00001234, 0, 0, 1);
        check("sh_web", {28'd0, acc_web}, 32'h3);
        check("sh_di", acc_di, 32'h12341234);
        do_req("sh_8000", 1, H, 32'h8000, 32'h0000beef, 0, 0, 1);
        check("sh0_web", {28'd0, acc_web}, 32'hc);
        do_req("lw_after_sh", 0, W, 32'h8000, 0, 32'h1234beef, 0, 2);

        do_req("lw_mis", 0, W, 32'h8002, 0, 0, 1, 1);
        do_req("sh_mis", 1, H, 32'h8001, 32'h1, 0, 1, 1);
        do_req("lw_oor", 0, W, 32'h10000, 0, 0, 1, 1);
        do_req("sbu_ill", 1, BU, 32'h8000, 32'h1, 0, 1, 1);
        do_req("f3_011", 0, 3'b011, 32'h8000, 0, 0, 1, 1);

        do_req("sw_end", 1, W, 32'hfffc, 32'hffffffff, 0, 0, 1);
        check("sw_end_a", {18'd0, acc_a}, 32'h3fff);
        @(negedge clk);
        check("simdone_set", {31'd0, sim_done}, 32'd1);
        do_req("sb_after_end", 1, B, 32'hfffc, 32'h00000011, 0, 0, 1);
        do_req("lw_end", 0, W, 32'hfffc, 0, 32'hffffff11, 0, 2);
        check("simdone_sticky", {31'd0, sim_done}, 32'd1);

        begin
            int cs0;
            @(negedge clk);
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = W;
            req_addr   = 32'h8000;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rst = 1'b0;
            cs0 = cs_cnt;
            @(negedge clk);
            check("abort_cs_gated", {31'd0, dm_cs}, 32'd0);
            @(negedge clk);
            check("abort_no_access", cs_cnt, cs0);
            check("abort_valid", {31'd0, resp_valid}, 32'd0);
            check("abort_ready", {31'd0, req_ready}, 32'd0);
            check("abort_web", {28'd0, dm_web}, 32'hf);
            check("abort_a", {18'd0, dm_a}, 32'd0);
            check("abort_di", dm_di, 32'd0);
            check("abort_simdone", {31'd0, sim_done}, 32'd0);
            rst = 1'b1;
            @(negedge clk);
            check("abort_no_late_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_req("lw_after_abort", 0, W, 32'h8000, 0, 32'h1234beef, 0, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
